acc_reg_file: RTL and testbench

- Parametrised accumulator-style register file: NREGS general registers plus one result register (res) feeding the ALU.
- Adds asynchronous reset, a register/res swap, and a split-transaction memory-load port with a one-deep pending-load tag.
- Hazard stall and load-data forwarding let the core keep issuing while a load is outstanding.
- Sits between the decoder/ALU and data memory; the two compare operands are exported as fixed taps.

---
 rtl/acc_reg_file_pkg.sv | 27 ++
 rtl/acc_reg_file_if.sv | 37 +++
 rtl/acc_load_tracker.sv | 63 ++++++
 rtl/acc_reg_file.sv | 69 ++++++
 tb/tb_acc_reg_file.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/acc_reg_file_pkg.sv
// rtl/acc_reg_file_pkg.sv - shared load-FSM states and op-priority encoding
package acc_reg_file_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } ld_state_t;

    typedef enum logic [2:0] {
        OP_NONE   = 3'd0,
        OP_ALU    = 3'd1,
        OP_CPYIN  = 3'd2,
        OP_CPYOUT = 3'd3,
        OP_SWAP   = 3'd4
    } op_t;

    // One op per cycle: swap > cpyout > cpyin > alu_we.
    function automatic op_t op_decode(input logic swap, input logic cpyout,
                                      input logic cpyin, input logic alu_we);
        if (swap)        return OP_SWAP;
        else if (cpyout) return OP_CPYOUT;
        else if (cpyin)  return OP_CPYIN;
        else if (alu_we) return OP_ALU;
        else             return OP_NONE;
    endfunction

endpackage

// File: rtl/acc_reg_file_if.sv
// rtl/acc_reg_file_if.sv - core/memory-side bundle of the accumulator register file
interface acc_reg_file_if #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
);
    localparam int SELW = $clog2(NREGS);

    logic [SELW-1:0]  reg_sel;
    logic             cpyin;
    logic             cpyout;
    logic             swap;
    logic             alu_we;
    logic [WIDTH-1:0] write_data;
    logic             ld_req;
    logic [SELW-1:0]  ld_sel;
    logic             ld_valid;
    logic [WIDTH-1:0] ld_data;
    logic             ld_busy;
    logic             ld_err;
    logic             stall;
    logic [WIDTH-1:0] reg_val;
    logic [WIDTH-1:0] res_val;
    logic [WIDTH-1:0] cone_reg;
    logic [WIDTH-1:0] ctwo_reg;

    modport master (
        output reg_sel, cpyin, cpyout, swap, alu_we, write_data,
        output ld_req, ld_sel, ld_valid, ld_data,
        input  ld_busy, ld_err, stall, reg_val, res_val, cone_reg, ctwo_reg
    );

    modport slave (
        input  reg_sel, cpyin, cpyout, swap, alu_we, write_data,
        input  ld_req, ld_sel, ld_valid, ld_data,
        output ld_busy, ld_err, stall, reg_val, res_val, cone_reg, ctwo_reg
    );
endinterface

// File: rtl/acc_load_tracker.sv
// rtl/acc_load_tracker.sv - one-deep pending-load tracker: tag, busy, error, hazard and forward select
module acc_load_tracker
    import acc_reg_file_pkg::*;
#(
    parameter int SELW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld_req,
    input  logic [SELW-1:0] ld_sel,
    input  logic            ld_valid,
    input  logic [SELW-1:0] reg_sel,
    input  logic            reg_op,
    output logic            ld_busy,
    output logic            ld_err,
    output logic            stall,
    output logic            fwd,
    output logic            ld_we,
    output logic [SELW-1:0] tag
);
    ld_state_t state;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tag     <= '0;
            ld_busy <= 1'b0;
            ld_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ld_req) begin
                        state   <= WAIT;
                        tag     <= ld_sel;
                        ld_busy <= 1'b1;
                    end
                end
                WAIT: begin
                    if (ld_valid) begin
                        // A new request on the completing cycle chains straight into WAIT.
                        if (ld_req) begin
                            tag <= ld_sel;
                        end else begin
                            state   <= IDLE;
                            ld_busy <= 1'b0;
                        end
                    end else if (ld_req) begin
                        ld_err <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ld_busy <= 1'b0;
                end
            endcase
        end
    end

    assign ld_we = (state == WAIT) && ld_valid;
    assign fwd   = ld_we && (reg_sel == tag);
    assign stall = (state == WAIT) && !ld_valid && (reg_sel == tag) && reg_op;

endmodule

// File: rtl/acc_reg_file.sv
// rtl/acc_reg_file.sv - accumulator register file with res swap, split-transaction loads and forwarding
module acc_reg_file
    import acc_reg_file_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int NREGS    = 8,
    parameter int SELW     = $clog2(NREGS),
    parameter int CONE_IDX = NREGS - 2,
    parameter int CTWO_IDX = NREGS - 1
) (
    input logic          clk,
    input logic          rst,
    acc_reg_file_if.slave bus
);
    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] rd_val;
    logic [SELW-1:0]  tag;
    logic             stall;
    logic             fwd;
    logic             ld_we;
    op_t              op;

    acc_load_tracker #(.SELW(SELW)) u_tracker (
        .clk      (clk),
        .rst      (rst),
        .ld_req   (bus.ld_req),
        .ld_sel   (bus.ld_sel),
        .ld_valid (bus.ld_valid),
        .reg_sel  (bus.reg_sel),
        .reg_op   (bus.swap | bus.cpyout | bus.cpyin),
        .ld_busy  (bus.ld_busy),
        .ld_err   (bus.ld_err),
        .stall    (stall),
        .fwd      (fwd),
        .ld_we    (ld_we),
        .tag      (tag)
    );

    assign op     = stall ? OP_NONE : op_decode(bus.swap, bus.cpyout, bus.cpyin, bus.alu_we);
    assign rd_val = fwd ? bus.ld_data : regs[bus.reg_sel];

    // The op write is issued after the load write so it wins on a same-register collision.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            res <= '0;
        end else begin
            if (ld_we) regs[tag] <= bus.ld_data;
            case (op)
                OP_SWAP: begin
                    res                <= rd_val;
                    regs[bus.reg_sel]  <= res;
                end
                OP_CPYOUT: regs[bus.reg_sel] <= res;
                OP_CPYIN:  res <= rd_val;
                OP_ALU:    res <= bus.write_data;
                default:   ;
            endcase
        end
    end

    assign bus.stall    = stall;
    assign bus.reg_val  = rd_val;
    assign bus.res_val  = res;
    assign bus.cone_reg = regs[CONE_IDX];
    assign bus.ctwo_reg = regs[CTWO_IDX];

endmodule

// File: tb/tb_acc_reg_file.sv
// tb/tb_acc_reg_file.sv - scoreboard bench for acc_reg_file with directed vectors
module tb_acc_reg_file;
    typedef enum logic [2:0] {
        S_RES, S_REGVAL, S_STALL, S_BUSY, S_ERR, S_CONE, S_CTWO
    } sig_t;

    typedef struct {
        string       name;
        sig_t        sig;
        logic [15:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    acc_reg_file_if #(.WIDTH(16), .NREGS(8)) bus ();

    acc_reg_file #(.WIDTH(16), .NREGS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] sample(sig_t s);
        case (s)
            S_RES:    return bus.res_val;
            S_REGVAL: return bus.reg_val;
            S_STALL:  return {15'b0, bus.stall};
            S_BUSY:   return {15'b0, bus.ld_busy};
            S_ERR:    return {15'b0, bus.ld_err};
            S_CONE:   return bus.cone_reg;
            default:  return bus.ctwo_reg;
        endcase
    endfunction

    // Monitor: state changes on negedge, so everything queued is checked on the posedge.
    always @(posedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            logic [15:0] act;
            e   = sb.pop_front();
            act = sample(e.sig);
            checks++;
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.val);
            end
        end
    end

    task automatic expect_sig(string name, sig_t s, logic [15:0] v);
        exp_t e;
        e.name = name;
        e.sig  = s;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic expect_reg(string name, logic [2:0] n, logic [15:0] v);
        bus.reg_sel = n;
        expect_sig(name, S_REGVAL, v);
    endtask

    task automatic clear_inputs();
        bus.cpyin = 0; bus.cpyout = 0; bus.swap = 0; bus.alu_we = 0;
        bus.ld_req = 0; bus.ld_valid = 0;
    endtask

    // Apply current inputs at the next falling edge, then drop the strobes.
    task automatic tick();
        @(negedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic alu(logic [15:0] d);
        bus.alu_we = 1; bus.write_data = d; tick();
    endtask

    task automatic cpyout(logic [2:0] n);
        bus.cpyout = 1; bus.reg_sel = n; tick();
    endtask

    task automatic ld_start(logic [2:0] n);
        bus.ld_req = 1; bus.ld_sel = n; tick();
    endtask

    initial begin
        clear_inputs();
        bus.reg_sel = 0; bus.ld_sel = 0; bus.write_data = 0; bus.ld_data = 0;

        expect_sig("rst_res",  S_RES,  16'h0);
        expect_sig("rst_busy", S_BUSY, 16'h0);
        expect_sig("rst_err",  S_ERR,  16'h0);
        expect_sig("rst_cone", S_CONE, 16'h0);
        expect_reg("rst_reg0", 3'd0,   16'h0);
        @(negedge clk); #1; rst = 0;

        alu(16'h1234);
        expect_sig("alu_res", S_RES, 16'h1234);
        cpyout(3'd3);
        expect_reg("cpyout_reg3", 3'd3, 16'h1234);
        expect_sig("cpyout_res", S_RES, 16'h1234);

        alu(16'h5500); cpyout(3'd2); alu(16'h00AA);
        bus.swap = 1; bus.reg_sel = 2; tick();
        expect_sig("swap_res", S_RES, 16'h5500);
        expect_reg("swap_reg2", 3'd2, 16'h00AA);

        ld_start(3'd5);
        expect_sig("ld5_busy", S_BUSY, 16'h1);
        bus.cpyin = 1; bus.reg_sel = 5;
        expect_sig("hazard_stall", S_STALL, 16'h1);
        tick();
        expect_sig("hazard_res_held", S_RES, 16'h5500);
        expect_sig("hazard_busy", S_BUSY, 16'h1);
        bus.cpyin = 1; bus.reg_sel = 5; bus.ld_valid = 1; bus.ld_data = 16'hBEEF;
        expect_sig("fwd_stall", S_STALL, 16'h0);
        expect_sig("fwd_regval", S_REGVAL, 16'hBEEF);
        tick();
        expect_sig("fwd_res", S_RES, 16'hBEEF);
        expect_reg("fwd_reg5", 3'd5, 16'hBEEF);
        expect_sig("fwd_busy", S_BUSY, 16'h0);

        ld_start(3'd1);
        bus.ld_valid = 1; bus.ld_data = 16'h0001; bus.ld_req = 1; bus.ld_sel = 6; tick();
        expect_reg("b2b_reg1", 3'd1, 16'h0001);
        expect_sig("b2b_busy", S_BUSY, 16'h1);
        bus.ld_valid = 1; bus.ld_data = 16'h0606; tick();
        expect_sig("b2b_cone", S_CONE, 16'h0606);
        expect_sig("b2b_idle", S_BUSY, 16'h0);

        ld_start(3'd7);
        bus.ld_req = 1; bus.ld_sel = 3; tick();
        expect_sig("drop_err", S_ERR, 16'h1);
        expect_sig("drop_busy", S_BUSY, 16'h1);
        bus.ld_valid = 1; bus.ld_data = 16'h7A7A; tick();
        expect_sig("drop_tag_ctwo", S_CTWO, 16'h7A7A);
        expect_reg("drop_reg3", 3'd3, 16'h1234);
        expect_sig("drop_err_sticky", S_ERR, 16'h1);

        ld_start(3'd4);
        bus.alu_we = 1; bus.write_data = 16'h7777; bus.reg_sel = 4;
        expect_sig("alu_nostall", S_STALL, 16'h0);
        tick();
        bus.cpyout = 1; bus.reg_sel = 4; bus.ld_valid = 1; bus.ld_data = 16'h1111; tick();
        expect_reg("collide_reg4", 3'd4, 16'h7777);
        expect_sig("collide_busy", S_BUSY, 16'h0);
        ld_start(3'd0);
        bus.cpyout = 1; bus.reg_sel = 2; bus.ld_valid = 1; bus.ld_data = 16'h2222; tick();
        expect_reg("split_reg0", 3'd0, 16'h2222);
        tick();
        expect_reg("split_reg2", 3'd2, 16'h7777);
        expect_sig("err_still", S_ERR, 16'h1);

        ld_start(3'd5);
        rst = 1;
        expect_sig("midrst_res",  S_RES,  16'h0);
        expect_sig("midrst_busy", S_BUSY, 16'h0);
        expect_sig("midrst_err",  S_ERR,  16'h0);
        expect_sig("midrst_cone", S_CONE, 16'h0);
        expect_sig("midrst_ctwo", S_CTWO, 16'h0);
        expect_reg("midrst_reg3", 3'd3,   16'h0);
        tick();
        rst = 0;
        bus.ld_valid = 1; bus.ld_data = 16'h5555; tick();
        expect_reg("late_valid_reg5", 3'd5, 16'h0);
        expect_sig("late_valid_busy", S_BUSY, 16'h0);

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
